// File: rtl/aidc_lite_ahb_slv_mem_if.sv
// AHB-Lite slave bus bundle for aidc_lite_ahb_slv_mem.
// Signals:
//   hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i : address phase
//   hwdata_i                                               : write data
//   hready_i                                               : bus HREADY
//   hready_o, hresp_o, hrdata_o                            : slave response
// master modport drives the requests, slave modport answers them.
interface aidc_lite_ahb_slv_mem_if;
    logic        hsel_i;
    logic [31:0] haddr_i;
    logic [1:0]  htrans_i;
    logic        hwrite_i;
    logic [2:0]  hsize_i;
    logic [2:0]  hburst_i;
    logic [31:0] hwdata_i;
    logic        hready_i;
    logic        hready_o;
    logic [1:0]  hresp_o;
    logic [31:0] hrdata_o;

    modport master (
        output hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i,
               hwdata_i, hready_i,
        input  hready_o, hresp_o, hrdata_o
    );

    modport slave (
        input  hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i,
               hwdata_i, hready_i,
        output hready_o, hresp_o, hrdata_o
    );
endinterface

// File: rtl/aidc_lite_ahb_slv_mem.sv
// AHB-Lite word-addressed memory slave (32-bit words only).
// Ports:
//   clk : clock, all logic on rising edge
//   rst : asynchronous active-high reset
//   bus : aidc_lite_ahb_slv_mem_if.slave (AHB-Lite slave signals)
// Parameters: BASE_ADDR (window base), MEM_DEPTH (words, power of two),
//   WAIT_CYCLES (wait states on NONSEQ data phases, 0..7).
// Macro AIDC_LITE_AHB_SLV_WAIT_EN: when defined, NONSEQ data phases get
//   WAIT_CYCLES wait states; otherwise every valid data phase is zero-wait.
module aidc_lite_ahb_slv_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MEM_DEPTH   = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    aidc_lite_ahb_slv_mem_if.slave        bus
);
    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [32:0] WIN_BYTES = 33'(MEM_DEPTH) << 2;
    localparam logic [1:0]  OKAY      = 2'b00;
    localparam logic [1:0]  ERROR     = 2'b01;
`ifdef AIDC_LITE_AHB_SLV_WAIT_EN
    localparam logic [2:0]  WAIT_CNT  = 3'(WAIT_CYCLES);
`else
    localparam logic [2:0]  WAIT_CNT  = 3'd0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        state;
    logic [2:0]    wait_cnt;
    logic [AW-1:0] idx_q;
    logic          hwrite_q;
    logic [31:0]   mem [MEM_DEPTH];

    logic          accept;
    logic          addr_err;
    logic          nonseq;
    logic          use_wait;
    logic [31:0]   offset;
    logic [AW-1:0] idx_a;
    logic [AW-1:0] rd_idx;
    logic          load_rd;
    logic          bypass;
    logic [31:0]   rd_word;
    logic          unused_burst;

    assign unused_burst = ^bus.hburst_i;

    // hready_o is only high in states that can take a new address phase
    assign accept   = bus.hsel_i & bus.htrans_i[1] & bus.hready_i & bus.hready_o;
    assign offset   = bus.haddr_i - BASE_ADDR;
    assign addr_err = (bus.hsize_i != 3'b010) || (bus.haddr_i[1:0] != 2'b00) ||
                      (bus.haddr_i < BASE_ADDR) || ({1'b0, offset} >= WIN_BYTES);
    assign nonseq   = (bus.htrans_i == 2'b10);
    assign use_wait = nonseq && (WAIT_CNT != 3'd0);
    assign idx_a    = offset[AW+1:2];

    // Read data is registered on the edge that enters S_DATA so it is
    // valid for the whole data phase.
    assign load_rd = ((state == S_WAIT) && (wait_cnt <= 3'd1) && !hwrite_q) ||
                     (accept && !addr_err && !bus.hwrite_i && !use_wait);
    assign rd_idx  = (state == S_WAIT) ? idx_q : idx_a;
    // A write finishing on this same edge has not reached the array yet.
    assign bypass  = (state == S_DATA) && hwrite_q && (idx_q == rd_idx);
    assign rd_word = bypass ? bus.hwdata_i : mem[rd_idx];

    // Array is not reset; a write pending when rst rises is dropped.
    always_ff @(posedge clk) begin
        if (!rst && (state == S_DATA) && hwrite_q)
            mem[idx_q] <= bus.hwdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            wait_cnt     <= 3'd0;
            idx_q        <= '0;
            hwrite_q     <= 1'b0;
            bus.hready_o <= 1'b1;
            bus.hresp_o  <= OKAY;
            bus.hrdata_o <= 32'h0;
        end else begin
            case (state)
                S_IDLE, S_DATA, S_ERR2: begin
                    if (accept) begin
                        if (addr_err) begin
                            state        <= S_ERR1;
                            hwrite_q     <= 1'b0;
                            bus.hready_o <= 1'b0;
                            bus.hresp_o  <= ERROR;
                        end else if (use_wait) begin
                            state        <= S_WAIT;
                            wait_cnt     <= WAIT_CNT;
                            idx_q        <= idx_a;
                            hwrite_q     <= bus.hwrite_i;
                            bus.hready_o <= 1'b0;
                            bus.hresp_o  <= OKAY;
                        end else begin
                            state        <= S_DATA;
                            idx_q        <= idx_a;
                            hwrite_q     <= bus.hwrite_i;
                            bus.hready_o <= 1'b1;
                            bus.hresp_o  <= OKAY;
                        end
                    end else begin
                        state        <= S_IDLE;
                        hwrite_q     <= 1'b0;
                        bus.hready_o <= 1'b1;
                        bus.hresp_o  <= OKAY;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt <= 3'd1) begin
                        state        <= S_DATA;
                        wait_cnt     <= 3'd0;
                        bus.hready_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_ERR1: begin
                    state        <= S_ERR2;
                    bus.hready_o <= 1'b1;
                    bus.hresp_o  <= ERROR;
                end
                default: begin
                    state        <= S_IDLE;
                    bus.hready_o <= 1'b1;
                    bus.hresp_o  <= OKAY;
                end
            endcase
            if (load_rd)
                bus.hrdata_o <= rd_word;
        end
    end
endmodule

// File: tb/tb_aidc_lite_ahb_slv_mem.sv
// Self-checking bench for aidc_lite_ahb_slv_mem: pipelined AHB master,
// memory model and scoreboard of expected data-phase results.
module tb_aidc_lite_ahb_slv_mem;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;
    localparam int          WCYC  = 2;
`ifdef AIDC_LITE_AHB_SLV_WAIT_EN
    localparam int          W     = WCYC;
`else
    localparam int          W     = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aidc_lite_ahb_slv_mem_if bus ();
    assign bus.hready_i = bus.hready_o;

    aidc_lite_ahb_slv_mem #(
        .BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(WCYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic        rd;
        logic        err;
        logic [31:0] data;
        int          idx;
        int          beat;
    } exp_t;

    txn_t        q[$];
    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          checks   = 0;
    int          failures = 0;
    int          dc, wc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input txn_t t);
        longint a;
        a = longint'(t.addr);
        return (t.size != 3'b010) || (t.addr[1:0] != 2'b00) ||
               (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * DEPTH);
    endfunction

    task automatic drive_idle();
        bus.hsel_i   = 1'b0;
        bus.htrans_i = 2'b00;
        bus.haddr_i  = 32'h0;
        bus.hwrite_i = 1'b0;
        bus.hsize_i  = 3'b010;
        bus.hburst_i = 3'b000;
    endtask

    task automatic push(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                        input logic wr, input logic [2:0] size, input logic [31:0] wdata);
        txn_t t;
        t.sel = sel; t.trans = trans; t.addr = addr; t.wr = wr;
        t.size = size; t.burst = 3'b000; t.wdata = wdata;
        q.push_back(t);
    endtask

    task automatic burst16(input logic [31:0] addr, input logic wr, input logic [31:0] d0);
        txn_t t;
        for (int i = 0; i < 16; i++) begin
            t.sel = 1'b1; t.trans = (i == 0) ? 2'b10 : 2'b11; t.addr = addr + 32'(4 * i);
            t.wr = wr; t.size = 3'b010; t.burst = 3'b111; t.wdata = d0 + 32'(i);
            q.push_back(t);
        end
    endtask

    // Runs the queued transfers as a pipelined master. Called at posedge+1.
    // rst_beat >= 0 asserts reset during that beat's data phase.
    task automatic run(input int rst_beat, output int dcyc, output int wcyc);
        txn_t        t;
        exp_t        e;
        exp_t        p;
        logic [31:0] dp_wd, nxt_wd;
        bit          acc, idle_chk;
        int          guard, beats;
        dp_wd = 32'h0; nxt_wd = 32'h0; idle_chk = 0;
        dcyc = 0; wcyc = 0; guard = 0; beats = 0;
        while ((q.size() > 0 || sb.size() > 0) && guard < 2000) begin
            guard++;
            acc = 0;
            bus.hwdata_i = dp_wd;
            if (idle_chk) begin
                chk("idle_ready", 32'(bus.hready_o), 32'd1);
                chk("idle_resp", 32'(bus.hresp_o), 32'd0);
                idle_chk = 0;
            end
            if (sb.size() > 0) dcyc++;
            if (sb.size() > 0 && sb[0].beat == rst_beat && bus.hready_o) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_mid_ready", 32'(bus.hready_o), 32'd1);
                chk("rst_mid_resp", 32'(bus.hresp_o), 32'd0);
                chk("rst_mid_rdata", bus.hrdata_o, 32'h0);
                q.delete();
                sb.delete();
                drive_idle();
                @(posedge clk);
                #1 rst = 1'b0;
                break;
            end
            if (bus.hready_o) begin
                if (sb.size() > 0) begin
                    p = sb.pop_front();
                    chk("resp", 32'(bus.hresp_o), p.err ? 32'd1 : 32'd0);
                    if (!p.err && p.rd) chk("rdata", bus.hrdata_o, p.data);
                    if (!p.err && !p.rd) model[p.idx] = p.data;
                end
                if (q.size() > 0) begin
                    t = q.pop_front();
                    bus.hsel_i   = t.sel;
                    bus.htrans_i = t.trans;
                    bus.haddr_i  = t.addr;
                    bus.hwrite_i = t.wr;
                    bus.hsize_i  = t.size;
                    bus.hburst_i = t.burst;
                    if (t.sel && t.trans[1]) begin
                        e.err  = is_err(t);
                        e.rd   = !t.wr;
                        e.beat = beats;
                        beats++;
                        e.idx  = e.err ? 0 : int'((t.addr - BASE) >> 2);
                        e.data = t.wr ? t.wdata : (e.err ? 32'h0 : model[e.idx]);
                        sb.push_back(e);
                        acc = 1;
                        nxt_wd = t.wdata;
                    end else if (sb.size() == 0) begin
                        idle_chk = 1;
                    end
                end else begin
                    drive_idle();
                end
            end else if (sb.size() > 0) begin
                wcyc++;
                if (sb[0].err) chk("err1_resp", 32'(bus.hresp_o), 32'd1);
            end
            @(posedge clk);
            #1;
            if (acc) dp_wd = nxt_wd;
        end
        chk("run_drained", 32'(q.size() + sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        bus.hwdata_i = 32'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(bus.hready_o), 32'd1);
        chk("reset_resp", 32'(bus.hresp_o), 32'd0);
        chk("reset_rdata", bus.hrdata_o, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        burst16(BASE + 32'h80, 1'b1, 32'h1000);
        run(-1, dc, wc);
        chk("wr16_waits", 32'(wc), 32'(W));
        chk("wr16_cycles", 32'(dc), 32'(16 + W));

        burst16(BASE + 32'h80, 1'b0, 32'h0);
        run(-1, dc, wc);
        chk("rd16_waits", 32'(wc), 32'(W));
        chk("rd16_cycles", 32'(dc), 32'(16 + W));

        push(1'b1, 2'b10, BASE + 32'h14, 1'b1, 3'b010, 32'hDEAD_BEEF);
        push(1'b1, 2'b10, BASE + 32'h14, 1'b0, 3'b010, 32'h0);
        run(-1, dc, wc);

        push(1'b1, 2'b10, BASE + 32'(4 * DEPTH), 1'b1, 3'b010, 32'hBAD0_0001);
        push(1'b1, 2'b10, BASE + 32'h14, 1'b1, 3'b001, 32'hBAD0_0002);
        push(1'b1, 2'b10, BASE + 32'h16, 1'b1, 3'b010, 32'hBAD0_0003);
        push(1'b1, 2'b10, BASE - 32'h4, 1'b1, 3'b010, 32'hBAD0_0004);
        push(1'b1, 2'b10, BASE + 32'h14, 1'b0, 3'b010, 32'h0);
        push(1'b1, 2'b10, BASE + 32'(4 * DEPTH - 4), 1'b1, 3'b010, 32'h600D_F00D);
        push(1'b1, 2'b10, BASE + 32'(4 * DEPTH - 4), 1'b0, 3'b010, 32'h0);
        run(-1, dc, wc);
        chk("err_cycles", 32'(dc), 32'(8 + 3 * (1 + W)));
        chk("err_stalls", 32'(wc), 32'(4 + 3 * W));

        push(1'b1, 2'b10, BASE + 32'h18, 1'b1, 3'b010, 32'h1234_5678);
        run(-1, dc, wc);
        chk("rdata_hold", bus.hrdata_o, 32'h600D_F00D);

        push(1'b1, 2'b00, BASE + 32'h14, 1'b1, 3'b010, 32'hFFFF_0000);
        push(1'b1, 2'b01, BASE + 32'h14, 1'b1, 3'b010, 32'hFFFF_0001);
        push(1'b0, 2'b10, BASE + 32'h14, 1'b1, 3'b010, 32'hFFFF_0002);
        push(1'b1, 2'b10, BASE + 32'h14, 1'b0, 3'b010, 32'h0);
        push(1'b1, 2'b10, BASE + 32'h18, 1'b0, 3'b010, 32'h0);
        run(-1, dc, wc);

        burst16(BASE + 32'h80, 1'b1, 32'h2000);
        run(7, dc, wc);
        @(posedge clk);
        #1;
        burst16(BASE + 32'h80, 1'b0, 32'h0);
        run(-1, dc, wc);
        chk("rst_beat7_kept", model[32 + 7], 32'h1007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
